// File: rtl/sliding_window_ctrl_if.sv
// Handshake and window-generator bundle for sliding_window_ctrl.
// The slave modport is the controller's view; the master modport is the
// view of the environment that drives pixels in and consumes windows.
interface sliding_window_ctrl_if #(
    parameter int BUS_SIZE = 25,
    parameter int ROW_W    = 9,
    parameter int COL_W    = 10
);
    // Upstream raster pixel stream
    logic                in_valid;
    logic                in_sof;
    logic [BUS_SIZE-1:0] in_data;
    logic                in_ready;

    // Window generator drive
    logic                sw_en;
    logic [BUS_SIZE-1:0] sw_data;

    // Window qualification towards the consumer
    logic                out_valid;
    logic                out_ready;
    logic [ROW_W-1:0]    out_row;
    logic [COL_W-1:0]    out_col;
    logic                out_last;

    // Frame status pulses
    logic                frame_done;
    logic                sof_err;

    modport slave (
        input  in_valid, in_sof, in_data, out_ready,
        output in_ready, sw_en, sw_data,
        output out_valid, out_row, out_col, out_last,
        output frame_done, sof_err
    );

    modport master (
        output in_valid, in_sof, in_data, out_ready,
        input  in_ready, sw_en, sw_data,
        input  out_valid, out_row, out_col, out_last,
        input  frame_done, sof_err
    );
endinterface

// File: rtl/sliding_window_ctrl.sv
// Sequencer for the line-buffer window generator of the blur path.
// Accepts a raster stream, drives the generator's shift enable/data, flushes
// with pad pixels after the last input pixel, and qualifies each window with
// valid/row/col/last under downstream backpressure.
// Optional build macro SW_CTRL_STATS_EN adds stall_cycles and win_count.
module sliding_window_ctrl #(
    parameter int                  NUMBER_OF_LINES = 3,
    parameter int                  WIDTH           = 640,
    parameter int                  HEIGHT          = 480,
    parameter int                  BUS_SIZE        = 25,
    parameter logic [BUS_SIZE-1:0] PAD_VALUE       = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    sliding_window_ctrl_if.slave    bus
`ifdef SW_CTRL_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             win_count
`endif
);

    localparam int BUF       = NUMBER_OF_LINES * WIDTH;
    localparam int TOTAL     = HEIGHT * WIDTH;
    localparam int FLUSH_END = TOTAL + WIDTH - NUMBER_OF_LINES;
    localparam int KW        = $clog2(TOTAL + WIDTH);
    localparam int ROW_W     = $clog2(HEIGHT);
    localparam int COL_W     = $clog2(WIDTH);

    // k value before the step that shifts in stream pixel BUF-1 (window 0,0)
    localparam logic [KW-1:0]    K_PRIME     = KW'(BUF - 1);
    // k value before the step that shifts in the last real pixel
    localparam logic [KW-1:0]    K_LAST_PX   = KW'(TOTAL - 1);
    // k value once every pad step has been issued
    localparam logic [KW-1:0]    K_FLUSH_END = KW'(FLUSH_END);
    localparam logic [COL_W-1:0] COL_MAX     = COL_W'(WIDTH - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(WIDTH - NUMBER_OF_LINES);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(HEIGHT - NUMBER_OF_LINES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [KW-1:0]    k_q,       k_d;
    logic             primed_q,  primed_d;
    logic [ROW_W-1:0] row_q,     row_d;
    logic [COL_W-1:0] col_q,     col_d;
    logic             valid_q,   valid_d;
    logic             last_q,    last_d;
    logic             sof_err_q, sof_err_d;

    logic             free;
    logic             in_ready_c;
    logic             sw_en_c;
    logic             adv;
    logic             consumed;

    // Position of the window that the next shift step would complete
    logic             step_primed;
    logic [ROW_W-1:0] step_row;
    logic [COL_W-1:0] step_col;
    logic             step_valid;
    logic             step_last;

    assign free     = !valid_q || bus.out_ready;
    assign adv      = sw_en_c;
    assign consumed = valid_q && bus.out_ready;

    // Input acceptance and shift enable per state; both forced low in reset
    always_comb begin
        in_ready_c = 1'b0;
        sw_en_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                sw_en_c    = bus.in_valid && bus.in_sof;
            end
            S_RUN: begin
                in_ready_c = free;
                sw_en_c    = bus.in_valid && free;
            end
            S_FLUSH: begin
                sw_en_c    = free && (k_q != K_FLUSH_END);
            end
            default: begin
                in_ready_c = 1'b0;
                sw_en_c    = 1'b0;
            end
        endcase
        if (reset) begin
            in_ready_c = 1'b0;
            sw_en_c    = 1'b0;
        end
    end

    // Wrap counters for the window origin q = p-(BUF-1); no division needed
    always_comb begin
        step_primed = primed_q;
        step_row    = row_q;
        step_col    = col_q;
        if (k_q == K_PRIME) begin
            step_primed = 1'b1;
            step_row    = '0;
            step_col    = '0;
        end else if (primed_q) begin
            if (col_q == COL_MAX) begin
                step_col = '0;
                step_row = row_q + 1'b1;
            end else begin
                step_col = col_q + 1'b1;
            end
        end else begin
            step_row = '0;
            step_col = '0;
        end
        // Horizontally wrapping windows and rows past the bottom are suppressed
        step_valid = step_primed && (step_col <= COL_LAST) && (step_row <= ROW_LAST);
        step_last  = step_primed && (step_col == COL_LAST) && (step_row == ROW_LAST);
    end

    // Next-state logic for the sequencer and the window qualifiers
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        primed_d  = primed_q;
        row_d     = row_q;
        col_d     = col_q;
        valid_d   = valid_q;
        last_d    = last_q;
        sof_err_d = 1'b0;

        // A consumed window with no new shift leaves nothing to present
        if (consumed && !adv) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && bus.in_sof) begin
                    state_d  = S_RUN;
                    k_d      = KW'(1);
                    primed_d = 1'b0;
                    row_d    = '0;
                    col_d    = '0;
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (adv) begin
                    if (bus.in_sof) begin
                        // Restart: this pixel becomes pixel 0, stale lines masked by !primed
                        sof_err_d = 1'b1;
                        k_d       = KW'(1);
                        primed_d  = 1'b0;
                        row_d     = '0;
                        col_d     = '0;
                        valid_d   = 1'b0;
                        last_d    = 1'b0;
                    end else begin
                        k_d      = k_q + 1'b1;
                        primed_d = step_primed;
                        row_d    = step_row;
                        col_d    = step_col;
                        valid_d  = step_valid;
                        last_d   = step_last;
                        if (k_q == K_LAST_PX) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (adv) begin
                    k_d      = k_q + 1'b1;
                    primed_d = step_primed;
                    row_d    = step_row;
                    col_d    = step_col;
                    valid_d  = step_valid;
                    last_d   = step_last;
                end else if (consumed && last_q) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // State and qualifier registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            primed_q  <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            primed_q  <= primed_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.sw_en      = sw_en_c;
    assign bus.sw_data    = (state_q == S_FLUSH) ? PAD_VALUE : bus.in_data;
    assign bus.out_valid  = valid_q;
    assign bus.out_row    = row_q;
    assign bus.out_col    = col_q;
    assign bus.out_last   = last_q;
    assign bus.frame_done = (state_q == S_DONE);
    assign bus.sof_err    = sof_err_q;

`ifdef SW_CTRL_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] win_q,   win_d;

    // Saturating stall and window counters, cleared at each frame start
    always_comb begin
        stall_d = stall_q;
        win_d   = win_q;
        if ((state_q == S_IDLE) && bus.in_valid && bus.in_sof) begin
            stall_d = '0;
            win_d   = '0;
        end else begin
            if (valid_q && !bus.out_ready && (stall_q != '1)) begin
                stall_d = stall_q + 32'd1;
            end
            if (consumed && (win_q != '1)) begin
                win_d = win_q + 32'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            win_q   <= '0;
        end else begin
            stall_q <= stall_d;
            win_q   <= win_d;
        end
    end

    assign stall_cycles = stall_q;
    assign win_count    = win_q;
`endif

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// Scoreboard bench for sliding_window_ctrl: the driver pushes the expected
// window list of each frame when its sof pixel is accepted, an independent
// negedge monitor pops and compares on every window handshake.
module tb_sliding_window_ctrl;
    localparam int N    = 3;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int BUS  = 25;
    localparam int RW   = $clog2(H);
    localparam int CW   = $clog2(W);
    localparam int BUFD = N * W;
    localparam int NWIN = (H - N + 1) * (W - N + 1);
    localparam logic [BUS-1:0] PAD = 25'h0155AA;

    typedef struct {
        int row;
        int col;
        bit last;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sliding_window_ctrl_if #(.BUS_SIZE(BUS), .ROW_W(RW), .COL_W(CW)) bus_if ();

`ifdef SW_CTRL_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] win_count;
`endif

    sliding_window_ctrl #(
        .NUMBER_OF_LINES(N),
        .WIDTH(W),
        .HEIGHT(H),
        .BUS_SIZE(BUS),
        .PAD_VALUE(PAD)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus_if)
`ifdef SW_CTRL_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .win_count(win_count)
`endif
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    win_t expq[$];

    // Driver-owned controls
    int rmode     = 0;
    int frame_no  = 0;
    bit chk_stats = 0;
    int exp_stall = 0;

    // Monitor-owned state
    int   done_cnt      = 0;
    int   win_in_frame  = 0;
    int   shift_cnt     = 0;
    int   pads          = 0;
    int   sof_err_seen  = 0;
    bit   first_pending = 0;
    bit   prev_stall    = 0;
    bit   prev_last_hs  = 0;
    bit   last_hs;
    int   prev_row, prev_col;
    bit   prev_last;
    win_t w;

    // out_ready generator state
    int stall_left    = 0;
    int stalled_frame = -1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference window order: raster over every non-wrapping origin
    task automatic push_frame();
        win_t e;
        for (int r = 0; r <= H - N; r++) begin
            for (int c = 0; c <= W - N; c++) begin
                e.row  = r;
                e.col  = c;
                e.last = (r == H - N) && (c == W - N);
                expq.push_back(e);
            end
        end
    endtask

    task automatic send_px(input logic [BUS-1:0] d, input bit sof, output bit ok);
        ok = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_sof   = sof;
        bus_if.in_data  = d;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if (bus_if.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus_if.in_valid = 1'b0;
        bus_if.in_sof   = 1'b0;
        if (!ok) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int npix, input bit gaps, input bit abort);
        bit ok;
        for (int i = 0; i < npix; i++) begin
            send_px(BUS'($urandom()), (i == 0), ok);
            if (!ok) return;
            if (i == 0) begin
                if (!abort) chk("queue_empty_at_sof", expq.size(), 0);
                expq.delete();
                push_frame();
                if (abort) begin
                    @(negedge clk);
                    chk("sof_err_pulse", int'(bus_if.sof_err), 1);
                    chk("abort_valid_drop", int'(bus_if.out_valid), 0);
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("sof_err_one_cycle", int'(bus_if.sof_err), 0);
                    @(posedge clk); #1;
                end
            end
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int t = 0; t < 3000 && done_cnt == start; t++) @(posedge clk);
        if (done_cnt == start) chk("frame_done_timeout", 0, 1);
        #1;
    endtask

    // Downstream ready: always, random, or one 4-cycle stall per frame
    always begin
        @(posedge clk);
        #1;
        case (rmode)
            0: bus_if.out_ready = 1'b1;
            1: bus_if.out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (stall_left > 0) begin
                    bus_if.out_ready = 1'b0;
                    stall_left--;
                end else if (stalled_frame != frame_no && win_in_frame >= 5 && bus_if.out_valid) begin
                    bus_if.out_ready = 1'b0;
                    stall_left       = 3;
                    stalled_frame    = frame_no;
                end else begin
                    bus_if.out_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor: window scoreboard, flush, latency and backpressure checks
    always @(negedge clk) begin
        if (rst) begin
            shift_cnt     = 0;
            first_pending = 0;
            prev_stall    = 0;
            prev_last_hs  = 0;
            pads          = 0;
            win_in_frame  = 0;
        end else begin
            last_hs = 0;
            if (bus_if.sof_err) sof_err_seen++;
            if (bus_if.frame_done || prev_last_hs) begin
                chk("frame_done", int'(bus_if.frame_done), int'(prev_last_hs));
                if (bus_if.frame_done) begin
                    chk("windows_per_frame", win_in_frame, NWIN);
                    chk("pad_steps", pads, W - N);
                    chk("leftover_windows", expq.size(), 0);
`ifdef SW_CTRL_STATS_EN
                    if (chk_stats) begin
                        chk("stall_cycles", int'(stall_cycles), exp_stall);
                        chk("win_count", int'(win_count), NWIN);
                    end
`endif
                    done_cnt++;
                end
            end
            if (prev_stall) begin
                chk("stall_valid_hold", int'(bus_if.out_valid), 1);
                chk("stall_row_hold", int'(bus_if.out_row), prev_row);
                chk("stall_col_hold", int'(bus_if.out_col), prev_col);
                chk("stall_last_hold", int'(bus_if.out_last), int'(prev_last));
            end
            if (bus_if.out_valid && !bus_if.out_ready) begin
                chk("stall_sw_en", int'(bus_if.sw_en), 0);
                chk("stall_in_ready", int'(bus_if.in_ready), 0);
            end
            if (bus_if.out_valid && first_pending) begin
                chk("first_window_latency", shift_cnt, BUFD);
                first_pending = 0;
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_window", 1, 0);
                end else begin
                    w = expq.pop_front();
                    chk("win_row", int'(bus_if.out_row), w.row);
                    chk("win_col", int'(bus_if.out_col), w.col);
                    chk("win_last", int'(bus_if.out_last), int'(w.last));
                end
                win_in_frame++;
                if (bus_if.out_last) last_hs = 1;
            end
            if (bus_if.sw_en) begin
                if (bus_if.in_valid && bus_if.in_ready) begin
                    chk("sw_data_pass", int'(bus_if.sw_data), int'(bus_if.in_data));
                    if (bus_if.in_sof) begin
                        shift_cnt     = 1;
                        first_pending = 1;
                        pads          = 0;
                        win_in_frame  = 0;
                    end else begin
                        shift_cnt++;
                    end
                end else begin
                    chk("sw_data_pad", int'(bus_if.sw_data), int'(PAD));
                    pads++;
                end
            end
            prev_stall   = bus_if.out_valid && !bus_if.out_ready;
            prev_row     = int'(bus_if.out_row);
            prev_col     = int'(bus_if.out_col);
            prev_last    = bus_if.out_last;
            prev_last_hs = last_hs;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_sof    = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_in_ready", int'(bus_if.in_ready), 0);
        chk("reset_sw_en", int'(bus_if.sw_en), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", int'(bus_if.out_valid), 0);
        chk("idle_out_last", int'(bus_if.out_last), 0);
        chk("idle_frame_done", int'(bus_if.frame_done), 0);
        chk("idle_sof_err", int'(bus_if.sof_err), 0);
        chk("idle_row", int'(bus_if.out_row), 0);
        chk("idle_col", int'(bus_if.out_col), 0);
        chk("idle_in_ready", int'(bus_if.in_ready), 1);
`ifdef SW_CTRL_STATS_EN
        chk("reset_stall_cycles", int'(stall_cycles), 0);
        chk("reset_win_count", int'(win_count), 0);
`endif
        @(posedge clk); #1;

        // Frame A: continuous stream, always ready
        frame_no++; rmode = 0; chk_stats = 1; exp_stall = 0;
        send_frame(H * W, 0, 0);
        wait_done();

        // Frame B: one 4-cycle downstream stall
        frame_no++; rmode = 2; chk_stats = 1; exp_stall = 4;
        send_frame(H * W, 0, 0);
        wait_done();

        // Pixels without sof in IDLE are dropped
        rmode = 0; chk_stats = 1; exp_stall = 0;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_sof   = 1'b0;
            bus_if.in_data  = BUS'($urandom());
            @(negedge clk);
            chk("nosof_in_ready", int'(bus_if.in_ready), 1);
            chk("nosof_sw_en", int'(bus_if.sw_en), 0);
            chk("nosof_out_valid", int'(bus_if.out_valid), 0);
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
        frame_no++;
        send_frame(H * W, 0, 0);
        wait_done();

        // Frame D: sof on pixel 30 restarts the frame
        frame_no++; chk_stats = 0;
        send_frame(30, 0, 0);
        send_frame(H * W, 0, 1);
        wait_done();

        // Frame E: reset during flush
        frame_no++;
        send_frame(H * W, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(bus_if.in_ready), 0);
        chk("rst_sw_en", int'(bus_if.sw_en), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_flush_out_valid", int'(bus_if.out_valid), 0);
        chk("rst_flush_frame_done", int'(bus_if.frame_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("post_rst_in_ready", int'(bus_if.in_ready), 1);
        chk("post_rst_out_valid", int'(bus_if.out_valid), 0);
        @(posedge clk); #1;

        // Frame F: fresh frame with random gaps and random backpressure
        frame_no++; rmode = 1;
        send_frame(H * W, 1, 0);
        wait_done();
        rmode = 0;
        repeat (4) begin @(posedge clk); #1; end

        chk("sof_err_total", sof_err_seen, 1);
        chk("frames_completed", done_cnt, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
